// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_stream_reader
//  Purpose  : Walks a word range of the 16-bit ROM on a start pulse and
//             delivers the returned words as a valid/ready stream.
//             A credit-controlled output FIFO hides the ROM read latency
//             and downstream back-pressure.
//
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             start             - run request, sampled only in IDLE
//             base_addr         - first byte address of the run
//             num_words         - word count (0 = done pulse, no reads)
//             busy, done        - run in progress / end-of-run pulse
//             rom_en, rom_addr  - registered ROM read request
//             rom_data          - ROM read data, RD_LAT cycles after request
//             m_valid, m_ready  - output stream handshake
//             m_data, m_last    - output word and end-of-run marker
//             checksum          - sum of popped words (optional)
//
//  Options  : ROM_READER_CHECKSUM_EN adds the `checksum` output port.
//
//  Revision : 1.0 - initial release
// ============================================================================
module rom_stream_reader #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 16,
    parameter int ADDR_STEP  = 2,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
`ifdef ROM_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              m_last
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_rom_en;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_issue_last;
    logic [RD_LAT-1:0]   r_pipe_vld;
    logic [RD_LAT-1:0]   r_pipe_last;
    logic [DATA_W:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_inflight;
    logic                r_zero_done;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_zero_req;
    logic [c_CNT_W:0]  w_reserved;
    logic              w_has_credit;
    logic              w_issue;
    logic              w_capture;
    logic              w_cap_last;
    logic              w_pop;
    logic              w_drain_done;
    logic [DATA_W:0]   w_head;

    assign w_accept   = (r_state == c_S_IDLE) && start && (num_words != '0);
    assign w_zero_req = (r_state == c_S_IDLE) && start && (num_words == '0);

    // Every issued read reserves a FIFO slot until it is popped, so the
    // capture path can never find the FIFO full. Same-cycle pops are not
    // credited back, which keeps the check a simple registered compare.
    assign w_reserved   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_has_credit = (w_reserved < c_DEPTH);
    assign w_issue      = (r_state == c_S_ISSUE) && (r_remaining != '0) && w_has_credit;

    assign w_capture  = r_pipe_vld[RD_LAT-1];
    assign w_cap_last = r_pipe_last[RD_LAT-1];
    assign w_pop      = m_valid && m_ready;

    assign w_drain_done = (r_state == c_S_DRAIN) && (r_inflight == c_CNT_ZERO)
                        && (r_count == c_CNT_ZERO);

    assign w_head = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (r_state != c_S_IDLE);
    assign done     = r_zero_done || w_drain_done;
    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;
    assign m_valid  = (r_count != c_CNT_ZERO);
    assign m_data   = w_head[DATA_W-1:0];
    assign m_last   = w_head[DATA_W];

    // ------------------------------------------------------------------
    // Sequencer FSM, address and remaining-count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_zero_req;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= base_addr;
                        r_remaining <= num_words;
                        r_state     <= c_S_ISSUE;
                    end
                end
                c_S_ISSUE: begin
                    if (w_issue) begin
                        // Address is modulo 2^ADDR_W; wrap is intentional.
                        r_addr      <= r_addr + ADDR_W'(ADDR_STEP);
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= c_S_DRAIN;
                        end
                    end
                end
                c_S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered ROM request and latency-matching tag pipe.
    // The pipe is fed from the registered request so that its output
    // lines up with rom_data RD_LAT cycles after the ROM samples it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_en     <= 1'b0;
            r_rom_addr   <= '0;
            r_issue_last <= 1'b0;
            r_pipe_vld   <= '0;
            r_pipe_last  <= '0;
        end else begin
            r_rom_en <= w_issue;
            if (w_issue) begin
                r_rom_addr   <= r_addr;
                r_issue_last <= (r_remaining == LEN_W'(1));
            end
            r_pipe_vld[0]  <= r_rom_en;
            r_pipe_last[0] <= r_rom_en && r_issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight counter: reads issued but not yet captured
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_capture})
                2'b10:   r_inflight <= r_inflight + c_CNT_ONE;
                2'b01:   r_inflight <= r_inflight - c_CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word fall-through output FIFO ({last, data} per entry)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_capture) begin
                r_mem[r_wr_ptr] <= {w_cap_last, rom_data};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running sum of popped words; cleared when a run is accepted
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_accept || w_zero_req) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + m_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_stream_reader
//  Purpose  : Self-checking bench for rom_stream_reader. Expected ROM
//             addresses and stream words are queued when each run is
//             started and compared as the DUT issues reads and pops words.
//             Define ROM_READER_CHECKSUM_EN to also exercise `checksum`.
//
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [18:0] base_addr = '0;
    logic [17:0] num_words = '0;
    logic        busy, done, rom_en, m_valid, m_last;
    logic [18:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] m_data;
    logic        m_ready = 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int compared   = 0;
    int mismatched = 0;
    int reads      = 0;
    int pops       = 0;
    int done_cnt   = 0;

    logic [16:0] exp_q[$];
    logic [18:0] addr_q[$];

    logic        stalled = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    always #5 clk = ~clk;

    rom_stream_reader #(
        .ADDR_W(19), .DATA_W(16), .ADDR_STEP(2), .RD_LAT(LAT),
        .FIFO_DEPTH(DEPTH), .LEN_W(18)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data),
`ifdef ROM_READER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .m_last(m_last)
    );

    // ROM contents: a few fixed words plus an address-derived pattern.
    function automatic logic [15:0] rom_word(input logic [18:0] a);
        case (a)
            19'h00100: return 16'h0001;
            19'h00102: return 16'hFFFF;
            19'h00104: return 16'h0010;
            default:   return {a[4:1], a[18:7]} ^ 16'hC35A;
        endcase
    endfunction

    // ROM model with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [18:0] b, input logic [17:0] n);
        logic [18:0] a;
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 19'(2 * i);
            addr_q.push_back(a);
            exp_q.push_back({(i == int'(n) - 1), rom_word(a)});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        while (m_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("wait_valid", m_valid, 1);
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("wait_done", done, 1);
    endtask

    task automatic chk_queues_empty(input string tag);
        chk({tag, "_addr_q"}, addr_q.size(), 0);
        chk({tag, "_exp_q"}, exp_q.size(), 0);
    endtask

    // Monitor: ROM requests, pops, credit bound, stall stability, done count.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (rom_en) begin
                reads++;
                compared++;
                assert (addr_q.size() != 0) else begin
                    mismatched++;
                    $error("FAIL rom_en_unexpected: observed addr %h expected no read", rom_addr);
                end
                if (addr_q.size() != 0) chk("rom_addr", rom_addr, addr_q.pop_front());
                chk("outstanding_le_depth", (reads - pops) <= DEPTH, 1);
            end
            if (stalled) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                compared++;
                assert (exp_q.size() != 0) else begin
                    mismatched++;
                    $error("FAIL pop_unexpected: observed data %h expected no word", m_data);
                end
                if (exp_q.size() != 0) chk("m_last_data", {m_last, m_data}, exp_q.pop_front());
                pops++;
            end
            stalled   = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        rst = 1'b0;
        tick();

        // ---------------- single word ----------------
        m_ready = 1'b1;
        start_run(19'h0, 18'd1);
        chk("sw_busy", busy, 1);
        chk("sw_rom_en_e0", rom_en, 0);
        chk("sw_valid_e0", m_valid, 0);
        tick();
        chk("sw_rom_en_e1", rom_en, 1);
        chk("sw_rom_addr_e1", rom_addr, 0);
        chk("sw_valid_e1", m_valid, 0);
        tick();
        chk("sw_rom_en_e2", rom_en, 0);
        chk("sw_valid_e2", m_valid, 0);
        tick();
        chk("sw_valid_e3", m_valid, 1);
        chk("sw_last_e3", m_last, 1);
        chk("sw_data_e3", m_data, rom_word(19'h0));
        tick();
        chk("sw_done", done, 1);
        chk("sw_valid_after_pop", m_valid, 0);
        tick();
        chk("sw_done_cleared", done, 0);
        chk("sw_busy_cleared", busy, 0);
        chk_queues_empty("sw");

        // ---------------- streaming, six words ----------------
        start_run(19'h0, 18'd6);
        wait_valid(20, n);
        chk("st_latency", n, LAT + 2);
        for (int i = 0; i < 6; i++) begin
            chk("st_throughput", m_valid, 1);
            tick();
        end
        chk("st_done", done, 1);
        tick();
        chk("st_busy_cleared", busy, 0);
        chk_queues_empty("st");

        // ---------------- back-pressure ----------------
        m_ready = 1'b0;
        reads = 0;
        pops  = 0;
        start_run(19'h00400, 18'd10);
        for (int i = 0; i < 20; i++) tick();
        chk("bp_reads_stalled", reads, DEPTH);
        chk("bp_busy", busy, 1);
        m_ready = 1'b1;
        wait_done(60);
        tick();
        chk("bp_pops", pops, 10);
        chk_queues_empty("bp");

        // ---------------- address wrap ----------------
        start_run(19'h7FFFE, 18'd3);
        wait_done(30);
        tick();
        chk_queues_empty("wrap");

        // ---------------- zero-length run ----------------
        d0 = done_cnt;
        reads = 0;
        start_run(19'h00010, 18'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_cleared", done, 0);
        tick(); tick();
        chk("zero_done_once", done_cnt - d0, 1);
        chk("zero_no_reads", reads, 0);

        // ---------------- reset mid-run ----------------
        reads = 0;
        pops  = 0;
        start_run(19'h00040, 18'd8);
        n = 0;
        while (pops < 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("mr_reached_word3", pops >= 3, 1);
        #3 rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_rom_en", rom_en, 0);
        chk("mr_rom_addr", rom_addr, 0);
        chk("mr_m_valid", m_valid, 0);
        chk("mr_m_data", m_data, 0);
        chk("mr_m_last", m_last, 0);
        exp_q.delete();
        addr_q.delete();
        d0 = done_cnt;
        tick(); tick();
        rst   = 1'b0;
        reads = 0;
        pops  = 0;
        tick(); tick();
        chk("mr_no_done", done_cnt - d0, 0);
        start_run(19'h00200, 18'd4);
        wait_done(30);
        tick();
        chk("mr_fresh_pops", pops, 4);
        chk("mr_fresh_done_once", done_cnt - d0, 1);
        chk_queues_empty("mr");

`ifdef ROM_READER_CHECKSUM_EN
        // ---------------- checksum ----------------
        start_run(19'h00100, 18'd3);
        wait_done(30);
        chk("cs_final", checksum, 16'h0010);
        tick();
        chk("cs_hold", checksum, 16'h0010);
        start_run(19'h0, 18'd1);
        chk("cs_cleared", checksum, 16'h0000);
        wait_done(30);
        tick();
        chk_queues_empty("cs");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
